appr_mul_seq_ctrl: RTL and testbench

- Sequencing controller for the approximate multiplier datapath.
- Drives a single carry-save compressor row iteratively over the multiplier bits.
- Accumulates partial products in redundant (sum/carry) form; resolves with one final carry-propagate add.
- Valid/ready on both sides; sits between the DFG operation scheduler and the result bus, letting one compressor row replace a full array.

---
 rtl/appr_mul_pkg.sv | 12 +
 rtl/csa_row.sv | 18 +
 rtl/appr_mul_seq_ctrl.sv | 117 +++++++++++
 tb/tb_appr_mul_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/appr_mul_pkg.sv
// appr_mul_pkg: shared state encoding, sizing constants and carry-mask helper for the sequential approximate multiplier
package appr_mul_pkg;
  typedef enum logic [1:0] {IDLE, ITER, RESOLVE, DONE} state_e;
  localparam int W_DEF = 16;
  localparam int IDX_W = $clog2(W_DEF);
  localparam int MASK_MAX = 128;
  function automatic logic [MASK_MAX-1:0] carry_mask(input int appr);
    logic [MASK_MAX-1:0] m;
    for (int i = 0; i < MASK_MAX; i++) m[i] = (i >= appr);
    return m;
  endfunction
endpackage

// File: rtl/csa_row.sv
// csa_row: one combinational 3:2 compressor row; carries landing in masked-off columns are dropped
module csa_row #(
  parameter int PW = 32
) (
  input  logic [PW-1:0] s,
  input  logic [PW-1:0] c,
  input  logic [PW-1:0] pp,
  input  logic [PW-1:0] mask,
  output logic [PW-1:0] s_n,
  output logic [PW-1:0] c_n
);
  logic [PW-1:0] maj;
  always_comb begin
    maj = (s & c) | (s & pp) | (c & pp);
    s_n = s ^ c ^ pp;
    c_n = {maj[PW-2:0], 1'b0} & mask;
  end
endmodule

// File: rtl/appr_mul_seq_ctrl.sv
// appr_mul_seq_ctrl: iterative carry-save multiplier controller with valid/ready on both sides
// Optional early termination on exhausted multiplier bits: APPR_MUL_SEQ_EARLY_TERM_EN
module appr_mul_seq_ctrl
  import appr_mul_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int APPR_BITS = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);
  localparam int PW = 2 * W;
  localparam int IW = (W == W_DEF) ? IDX_W : ((W > 1) ? $clog2(W) : 1);
  localparam logic [MASK_MAX-1:0] MASK_FULL = carry_mask(APPR_BITS);
  localparam logic [PW-1:0] C_MASK = MASK_FULL[PW-1:0];
  localparam logic [IW-1:0] LAST = IW'(W - 1);
`ifdef APPR_MUL_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  state_e          st_q, st_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [PW-1:0]   s_q, s_d, c_q, c_d, prod_q, prod_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            ov_q, ov_d, rdy_q, rdy_d, busy_q, busy_d;
  logic [PW-1:0]   pp, s_n, c_n;
  logic [IW:0]     nidx;
  logic            rest_zero;

  csa_row #(.PW(PW)) u_row (
    .s(s_q), .c(c_q), .pp(pp), .mask(C_MASK), .s_n(s_n), .c_n(c_n)
  );

  always_comb begin
    pp = b_q[idx_q] ? (PW'(a_q) << idx_q) : '0;
    nidx = {1'b0, idx_q} + (IW+1)'(1);
    rest_zero = (b_q >> nidx) == '0;
    st_d = st_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    c_d = c_q;
    idx_d = idx_q;
    prod_d = prod_q;
    ov_d = ov_q;
    case (st_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
        s_d = '0;
        c_d = '0;
        idx_d = '0;
        st_d = (EARLY && b == '0) ? RESOLVE : ITER;
      end
      ITER: begin
        s_d = s_n;
        c_d = c_n;
        // with early termination the remaining rows would all be zero
        if (idx_q == LAST || (EARLY && rest_zero)) st_d = RESOLVE;
        else idx_d = idx_q + IW'(1);
      end
      RESOLVE: begin
        prod_d = s_q + c_q;
        ov_d = 1'b1;
        st_d = DONE;
      end
      DONE: if (out_ready) begin
        ov_d = 1'b0;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    rdy_d = st_d == IDLE;
    busy_d = st_d != IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= '0;
      idx_q <= '0;
      prod_q <= '0;
      ov_q <= 1'b0;
      rdy_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      st_q <= st_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      c_q <= c_d;
      idx_q <= idx_d;
      prod_q <= prod_d;
      ov_q <= ov_d;
      rdy_q <= rdy_d;
      busy_q <= busy_d;
    end
  end

  assign in_ready = rdy_q;
  assign out_valid = ov_q;
  assign product = prod_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_appr_mul_seq_ctrl.sv
// tb_appr_mul_seq_ctrl: directed bench driving an exact and an APPR_BITS=8 instance in lockstep
module tb_appr_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [15:0] a, b;
  logic        ov0, ir0, busy0, ov1, ir1, busy1;
  logic [31:0] prod0, prod1;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  appr_mul_seq_ctrl #(.W(16), .APPR_BITS(0)) u_ex (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
    .out_valid(ov0), .out_ready(out_ready), .product(prod0), .busy(busy0)
  );
  appr_mul_seq_ctrl #(.W(16), .APPR_BITS(8)) u_ap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready), .product(prod1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input int appr);
    logic [31:0] s, c, pp, m, mj;
    s = '0;
    c = '0;
    for (int i = 0; i < 32; i++) m[i] = (i >= appr);
    for (int i = 0; i < 16; i++) begin
      pp = y[i] ? ({16'b0, x} << i) : 32'b0;
      mj = (s & c) | (s & pp) | (c & pp);
      s = s ^ c ^ pp;
      c = (mj << 1) & m;
`ifdef APPR_MUL_SEQ_EARLY_TERM_EN
      if ((y >> (i + 1)) == 16'b0) break;
`endif
    end
    return s + c;
  endfunction

  // edges from the accept edge to the edge that raises out_valid
  function automatic int exp_lat(input logic [15:0] y);
    int m;
    m = 0;
`ifdef APPR_MUL_SEQ_EARLY_TERM_EN
    if (y == 16'b0) return 1;
    for (int i = 0; i < 16; i++) if (y[i]) m = i;
    return m + 2;
`else
    m = 17;
    return m;
`endif
  endfunction

  task automatic start(input logic [15:0] x, input logic [15:0] y);
    int n;
    n = 0;
    while (!ir0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("ready_before_accept", ir0, 1'b1);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!ov0 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("ap_valid_aligned", ov1, ov0);
  endtask

  task automatic op(input logic [15:0] x, input logic [15:0] y);
    int lat;
    start(x, y);
    wait_valid(lat);
    chk("latency", lat, exp_lat(y));
    chk("exact", prod0, 32'(x) * 32'(y));
    chk("approx_model", prod1, model(x, y, 8));
    chk("approx_le_exact", prod1 <= prod0, 1'b1);
    chk("approx_err_small", (prod0 - prod1) < 32'h10000, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drops", ov0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov0, 1'b0);
    chk("rst_in_ready", ir0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_product", prod0, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", ir0, 1'b1);

    op(16'h1234, 16'h0000);
    op(16'hFFFF, 16'hFFFF);
    chk("corner_ffff", prod0, 32'hFFFE0001);

    start(16'h0055, 16'h00FF);
    repeat (5) @(posedge clk);
    #1;
    chk("midop_busy", busy0, 1'b1);
    chk("midop_held_product", prod0, 32'hFFFE0001);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", ov0, 1'b0);
    chk("async_rst_ready", ir0, 1'b1);
    chk("async_rst_product", prod0, 32'h0);
    chk("async_rst_ap_product", prod1, 32'h0);
    chk("async_rst_busy", busy0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    op(16'd3, 16'd5);
    chk("after_reset_3x5", prod0, 32'd15);

    start(16'h00FF, 16'h0101);
    wait_valid(lat);
    chk("bp_latency", lat, exp_lat(16'h0101));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", ov0, 1'b1);
      chk("bp_product", prod0, 32'h0000FFFF);
      chk("bp_in_ready", ir0, 1'b0);
      chk("bp_busy", busy0, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", ov0, 1'b0);
    chk("bp_release_idle", ir0, 1'b1);
    chk("bp_release_busy", busy0, 1'b0);

    in_valid = 1'b1;
    a = 16'd7;
    b = 16'd9;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_first_accept", busy0, 1'b1);
    a = 16'h8000;
    b = 16'd2;
    wait_valid(lat);
    chk("b2b_first_latency", lat, exp_lat(16'd9));
    chk("b2b_first_product", prod0, 32'd63);
    chk("b2b_first_ap", prod1, model(16'd7, 16'd9, 8));
    chk("b2b_no_accept_in_done", ir0, 1'b0);
    @(posedge clk); #1;
    chk("b2b_done_one_cycle", ov0, 1'b0);
    chk("b2b_idle_ready", ir0, 1'b1);
    chk("b2b_idle_not_busy", busy0, 1'b0);
    @(posedge clk); #1;
    chk("b2b_second_accept", busy0, 1'b1);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("b2b_second_latency", lat, exp_lat(16'd2));
    chk("b2b_second_product", prod0, 32'h00010000);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_second_drain", ov0, 1'b0);

    op(16'hABCD, 16'h0001);
    chk("one_times", prod0, 32'h0000ABCD);
    op(16'h1234, 16'h8000);
    op(16'h0000, 16'hFFFF);

    for (int i = 0; i < 200; i++) op(16'($urandom), 16'($urandom));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
